data_sram_responder: RTL
========================

Name: data_sram_responder

Overview:
- Data-side SRAM responder: the target end of the data_sram_en/wen/addr/wdata/rdata interface that the EX stage drives.
- Holds a word-organised, byte-writable storage array.
- Returns read data one cycle after acceptance, or after programmable wait states.
- When wait states are configured, it stalls the pipeline through stallreq_for_mem.
- Sits beside the MEM stage and replaces the external data RAM in block-level and core-level simulation.

Parameters:
ADDR_WIDTH, 10, word-index bits; the array holds 2**ADDR_WIDTH 32-bit words.
WAIT_CYCLES, 0, extra access latency in cycles; legal range 0..7.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
data_sram_en  input  1  access request this cycle
data_sram_wen  input  4  byte write enables; 4'b0000 means read
data_sram_addr  input  32  byte address
data_sram_wdata  input  32  write data, already lane-replicated by the initiator
data_sram_rdata  output  32  registered read word
resp_valid  output  1  data_sram_rdata holds a fresh read result this cycle
stallreq_for_mem  output  1  stall request to the pipeline controller
addr_err  output  1  one-cycle pulse on a rejected access (optional feature only)

Behaviour:
- Word index is data_sram_addr[ADDR_WIDTH+1:2]. Address bits above that index alias; addr[1:0] never selects storage. Byte lane i is written iff wen[i]=1, from wdata[8i+7:8i].
- Storage array has no reset. Its contents survive rst.
- Reset values: rdata=0, resp_valid=0, stallreq_for_mem=0, addr_err=0, state=IDLE, cnt=0, latched request cleared.
- WAIT_CYCLES=0:
  - No FSM activity; stallreq_for_mem is constant 0.
  - In cycle N with en=1: a write commits at the end of N; a read captures the word into rdata at the end of N.
  - resp_valid=1 in cycle N+1 for reads only. A write leaves rdata unchanged and resp_valid=0.
  - Back-to-back write then read of the same word returns the newly written bytes.
- WAIT_CYCLES=W>0, FSM with three states:
  - IDLE: en=1 makes stallreq_for_mem=1 combinationally in that cycle. On that edge: latch addr/wen/wdata, cnt<=W, go to WAIT. en=0 stays in IDLE.
  - WAIT: stallreq_for_mem=1; cnt decrements each cycle. When cnt==1, the latched access is performed at the edge (write commits / read captured into rdata) and the FSM goes to DONE.
  - DONE: stallreq_for_mem=0. resp_valid=1 if the latched access was a read. The inputs this cycle are the held original request and are ignored (no second access). The FSM returns to IDLE.
  - Net timing: stall asserted W+1 cycles (N..N+W); read data valid in cycle N+W+1.
- A request is never re-executed. en=0 while in WAIT does not abort the latched access.
- resp_valid is a single-cycle pulse. rdata holds its value until the next read capture.
- Reset asserted mid-operation: immediate return to IDLE with stall deasserted. A latched, uncommitted write is discarded. The array is unchanged except for any write already committed.

Optional Feature:
Macro: DATA_SRAM_ALIGN_CHECK_EN.
- Defined: an access is rejected if any of these holds:
  - wen=4'b1111 with addr[1:0]!=0;
  - wen in {0011,1100} with addr[0]=1;
  - wen is non-zero and not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- A rejected access: no array write, no rdata update, resp_valid=0. addr_err=1 for exactly one cycle, at the cycle the access would have completed (N+1, or N+W+1). Stall timing is unchanged.
- Undefined: addr_err is tied 0 and every wen pattern is written as given.

Test Plan:
- W=0: write addr 0x40, wen 1111, wdata 0xDEADBEEF; read 0x40 next cycle -> rdata=0xDEADBEEF and resp_valid=1 one cycle after the read; stallreq always 0.
- W=0: preload 0x11223344 at 0x80; byte write wen 0100, wdata 0xAAAAAAAA; read 0x80 -> 0x11AA3344.
- W=3: read 0x40 held with en=1 -> stallreq high exactly 4 cycles; rdata=0xDEADBEEF with resp_valid=1 in cycle 5; no second access in DONE.
- W=2: write issued, rst pulsed during WAIT -> stallreq=0 immediately, state IDLE; later read returns the old word.
- Aliasing, ADDR_WIDTH=10: write 0x00001004, read 0x00002004 -> same word returned.
- DATA_SRAM_ALIGN_CHECK_EN defined: wen 1111 at addr 0x42 -> addr_err pulse 1 cycle, word at 0x40 unchanged; macro undefined -> write performed, addr_err=0.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-side SRAM target: byte-writable word array with optional wait states.
// Define DATA_SRAM_ALIGN_CHECK_EN to reject misaligned or illegal wen accesses.
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic        stallreq_for_mem,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic                  do_acc;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [3:0]            acc_wen;
  logic [31:0]           acc_wdata;
  logic                  acc_bad;
  logic                  in_bad;
  logic                  unused;

  assign unused = ^{data_sram_addr[31:ADDR_WIDTH+2],
                    data_sram_addr[1:0]};

`ifdef DATA_SRAM_ALIGN_CHECK_EN
  always_comb begin
    in_bad = 1'b0;
    case (data_sram_wen)
      4'b0000, 4'b0001, 4'b0010,
      4'b0100, 4'b1000: in_bad = 1'b0;
      4'b0011, 4'b1100: in_bad = data_sram_addr[0];
      4'b1111:          in_bad = |data_sram_addr[1:0];
      default:          in_bad = 1'b1;
    endcase
  end
`else
  assign in_bad = 1'b0;
`endif

  if (WAIT_CYCLES == 0) begin : g_direct
    assign do_acc           = data_sram_en & ~rst;
    assign acc_idx          = data_sram_addr[ADDR_WIDTH+1:2];
    assign acc_wen          = data_sram_wen;
    assign acc_wdata        = data_sram_wdata;
    assign acc_bad          = in_bad;
    assign stallreq_for_mem = 1'b0;
  end else begin : g_wait
    typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
    } state_t;

    state_t                state;
    logic [2:0]            cnt;
    logic [ADDR_WIDTH-1:0] l_idx;
    logic [3:0]            l_wen;
    logic [31:0]           l_wdata;
    logic                  l_bad;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= S_IDLE;
        cnt     <= 3'd0;
        l_idx   <= '0;
        l_wen   <= 4'd0;
        l_wdata <= 32'd0;
        l_bad   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (data_sram_en) begin
              l_idx   <= data_sram_addr[ADDR_WIDTH+1:2];
              l_wen   <= data_sram_wen;
              l_wdata <= data_sram_wdata;
              l_bad   <= in_bad;
              cnt     <= 3'(WAIT_CYCLES);
              state   <= S_WAIT;
            end
          end
          S_WAIT: begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) state <= S_DONE;
          end
          // held request in this cycle is the one just served
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end

    assign stallreq_for_mem = ~rst &
      (((state == S_IDLE) & data_sram_en) |
       (state == S_WAIT));
    assign do_acc    = ~rst & (state == S_WAIT) &
                       (cnt == 3'd1);
    assign acc_idx   = l_idx;
    assign acc_wen   = l_wen;
    assign acc_wdata = l_wdata;
    assign acc_bad   = l_bad;
  end

  // storage deliberately has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (do_acc && !acc_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wen[i])
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sram_rdata <= 32'd0;
      resp_valid      <= 1'b0;
      addr_err        <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      addr_err   <= 1'b0;
      if (do_acc) begin
        if (acc_bad) begin
          addr_err <= 1'b1;
        end else if (acc_wen == 4'd0) begin
          data_sram_rdata <= mem[acc_idx];
          resp_valid      <= 1'b1;
        end
      end
    end
  end

endmodule
